// File: rtl/cr_kme_fifo_unpacker.sv
// Drains 71-bit KME RAM FIFO entries and emits two 32-bit beats per word.
// Ports: fifo_* pop side, out_* beat bus, stat_* saturating counters.
module cr_kme_fifo_unpacker #(
  parameter int DATA_SIZE = 71,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] fifo_out,
  input  logic                 fifo_out_valid,
  input  logic                 fifo_mbe,
  output logic                 fifo_out_ack,
  output logic [31:0]          out_data,
  output logic                 out_sot,
  output logic                 out_eot,
  output logic [4:0]           out_tag,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     stat_frames,
  output logic [CNT_W-1:0]     stat_mbe
);

  if (DATA_SIZE != 71) begin : g_bad_size
    $error("cr_kme_fifo_unpacker: DATA_SIZE must be 71");
  end

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    ERR,
    DROP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] h_data;
  logic        h_sot;
  logic        h_eot;
  logic [4:0]  h_tag;
  logic        ack;
  logic        pop;
  logic        cap;
  logic        fr_inc;
  logic        mbe_inc;

  // Ack is held low while reset is asserted so nothing is popped
  // before the state register is released.
  assign pop          = ack & ~rst;
  assign fifo_out_ack = pop;
  assign cap          = pop & (state_q != DROP);
  assign fr_inc       = out_valid & out_ready & out_eot;
  assign mbe_inc      = cap & fifo_mbe;

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ack = fifo_out_valid;
        if (fifo_out_valid)
          state_d = fifo_mbe ? ERR : HI;
      end
      HI: begin
        if (out_ready)
          state_d = LO;
      end
      LO: begin
        ack = fifo_out_valid & out_ready;
        if (out_ready) begin
          if (fifo_out_valid)
            state_d = fifo_mbe ? ERR : HI;
          else
            state_d = IDLE;
        end
      end
      ERR: begin
        if (out_ready)
          state_d = h_eot ? IDLE : DROP;
      end
      DROP: begin
        // mbe on dropped words is irrelevant; only eot ends the drop.
        ack = fifo_out_valid;
        if (fifo_out_valid && fifo_out[69])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sot   = 1'b0;
    out_eot   = 1'b0;
    out_tag   = '0;
    out_err   = 1'b0;
    unique case (state_q)
      HI: begin
        out_valid = 1'b1;
        out_data  = h_data[63:32];
        out_sot   = h_sot;
        out_tag   = h_tag;
      end
      LO: begin
        out_valid = 1'b1;
        out_data  = h_data[31:0];
        out_eot   = h_eot;
        out_tag   = h_tag;
      end
      ERR: begin
        out_valid = 1'b1;
        out_sot   = h_sot;
        out_eot   = 1'b1;
        out_tag   = h_tag;
        out_err   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      h_data      <= '0;
      h_sot       <= 1'b0;
      h_eot       <= 1'b0;
      h_tag       <= '0;
      stat_frames <= '0;
      stat_mbe    <= '0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        h_data <= fifo_out[63:0];
        h_sot  <= fifo_out[70];
        h_eot  <= fifo_out[69];
        h_tag  <= fifo_out[68:64];
      end
      if (fr_inc && stat_frames != '1)
        stat_frames <= stat_frames + 1'b1;
      if (mbe_inc && stat_mbe != '1)
        stat_mbe <= stat_mbe + 1'b1;
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_unpacker.sv
// Self-checking bench for cr_kme_fifo_unpacker.
// Table vectors, directed corner sequences and a random frame stream.
module tb_cr_kme_fifo_unpacker;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic        r;
    logic [4:0]  t;
  } beat_t;

  typedef struct packed {
    logic        m;
    logic [70:0] w;
  } ent_t;

  typedef struct {
    logic        m;
    logic        s;
    logic        e;
    logic [4:0]  t;
    logic [63:0] d;
    int          n;
    beat_t       b0;
    beat_t       b1;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [70:0]    fifo_out;
  logic           fifo_out_valid;
  logic           fifo_mbe;
  logic           fifo_out_ack;
  logic [31:0]    out_data;
  logic           out_sot;
  logic           out_eot;
  logic [4:0]     out_tag;
  logic           out_err;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  stat_frames;
  logic [CW-1:0]  stat_mbe;

  always #5 clk = ~clk;

  cr_kme_fifo_unpacker #(.DATA_SIZE(71), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
    .fifo_mbe(fifo_mbe), .fifo_out_ack(fifo_out_ack),
    .out_data(out_data), .out_sot(out_sot), .out_eot(out_eot),
    .out_tag(out_tag), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready),
    .stat_frames(stat_frames), .stat_mbe(stat_mbe)
  );

  int    nchk = 0;
  int    nfail = 0;
  ent_t  fq[$];
  beat_t got[$];
  beat_t exp_q[$];
  bit    m_drop;
  int    m_fr;
  int    m_mb;
  bit    prev_stall;
  beat_t prev_b;
  bit    s_ack;
  bit    s_valid;

  task automatic chk(string n, logic [63:0] act, logic [63:0] want);
    nchk++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, act, want);
    end
  endtask

  function automatic int sat(int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Reference model: word stream -> expected beat stream and counts.
  task automatic push_word(bit m, bit s, bit e, logic [4:0] t,
                           logic [63:0] d);
    fq.push_back({m, s, e, t, d});
    if (m_drop) begin
      if (e) m_drop = 0;
    end else if (m) begin
      exp_q.push_back({32'h0, s, 1'b1, 1'b1, t});
      m_mb++;
      m_fr++;
      if (!e) m_drop = 1;
    end else begin
      exp_q.push_back({d[63:32], s, 1'b0, 1'b0, t});
      exp_q.push_back({d[31:0], 1'b0, e, 1'b0, t});
      if (e) m_fr++;
    end
  endtask

  task automatic tick(bit rdy, bit ven);
    beat_t cur;
    @(negedge clk);
    out_ready = rdy;
    if (ven && fq.size() > 0) begin
      fifo_out_valid = 1'b1;
      fifo_out       = fq[0].w;
      fifo_mbe       = fq[0].m;
    end else begin
      fifo_out_valid = 1'b0;
      fifo_out       = '0;
      fifo_mbe       = 1'b0;
    end
    #1;
    s_ack   = fifo_out_ack;
    s_valid = out_valid;
    cur     = {out_data, out_sot, out_eot, out_err, out_tag};
    if (prev_stall) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_beat", 64'(cur), 64'(prev_b));
    end
    prev_stall = out_valid && !out_ready;
    prev_b     = cur;
    if (out_valid && out_ready) got.push_back(cur);
    @(posedge clk);
    if (fifo_out_valid && s_ack) void'(fq.pop_front());
  endtask

  task automatic run_until(int n, bit rnd);
    int cyc = 0;
    int lim = 20 * (fq.size() + n) + 50;
    s_valid = 1'b1;
    while (!(fq.size() == 0 && got.size() >= n && !s_valid)
           && cyc < lim) begin
      if (rnd) tick($urandom_range(3) != 0, $urandom_range(4) != 0);
      else     tick(1'b1, 1'b1);
      cyc++;
    end
    if (cyc >= lim) begin
      nchk++;
      nfail++;
      $display("FAIL timeout: got %0d beats expected %0d", got.size(), n);
    end
  endtask

  task automatic drain(bit rnd);
    run_until(exp_q.size(), rnd);
    chk("beat_count", 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("beat[%0d]", i), 64'(got[i]), 64'(exp_q[i]));
    chk("stat_frames", 64'(stat_frames), 64'(sat(m_fr)));
    chk("stat_mbe", 64'(stat_mbe), 64'(sat(m_mb)));
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fifo_out_valid = 1'b0;
    out_ready = 1'b0;
    fq.delete();
    got.delete();
    exp_q.delete();
    m_drop = 0;
    m_fr = 0;
    m_mb = 0;
    prev_stall = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 5'h0A, 64'h1122334455667788, 2,
               {32'h11223344, 1'b1, 1'b0, 1'b0, 5'h0A},
               {32'h55667788, 1'b0, 1'b1, 1'b0, 5'h0A}};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 5'h1F, 64'hDEADBEEFCAFEF00D, 2,
               {32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'h1F},
               {32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 5'h1F}};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 5'h03, 64'hFFFFFFFFFFFFFFFF, 1,
               {32'h0, 1'b1, 1'b1, 1'b1, 5'h03},
               {32'h0, 1'b0, 1'b0, 1'b0, 5'h00}};

    rst = 1'b1;
    out_ready = 1'b1;
    fifo_out_valid = 1'b1;
    fifo_mbe = 1'b0;
    fifo_out = {1'b1, 1'b1, 5'h01, 64'h1};
    prev_stall = 0;
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ack", 64'(fifo_out_ack), 64'd0);
    chk("rst_frames", 64'(stat_frames), 64'd0);
    chk("rst_mbe", 64'(stat_mbe), 64'd0);

    foreach (tbl[k]) begin
      do_reset();
      fq.push_back({tbl[k].m, tbl[k].s, tbl[k].e, tbl[k].t, tbl[k].d});
      tick(1'b1, 1'b1);
      chk("pop_ack", 64'(s_ack), 64'd1);
      chk("pop_novalid", 64'(s_valid), 64'd0);
      tick(1'b1, 1'b1);
      chk("latency1", 64'(s_valid), 64'd1);
      run_until(tbl[k].n, 1'b0);
      chk("tbl_count", 64'(got.size()), 64'(tbl[k].n));
      if (got.size() > 0) chk("tbl_b0", 64'(got[0]), 64'(tbl[k].b0));
      if (tbl[k].n == 2 && got.size() > 1)
        chk("tbl_b1", 64'(got[1]), 64'(tbl[k].b1));
      chk("tbl_frames", 64'(stat_frames), 64'd1);
      chk("tbl_mbe", 64'(stat_mbe), 64'(tbl[k].m));
      got.delete();
    end

    // 4-word frame at full rate: 8 back-to-back beats, ack on LO beats.
    do_reset();
    for (int i = 0; i < 4; i++)
      push_word(0, i == 0, i == 3, 5'h07, {32'(i), 32'(i + 100)});
    tick(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1);
      chk($sformatf("burst_valid[%0d]", i), 64'(s_valid), 64'd1);
      chk($sformatf("burst_ack[%0d]", i), 64'(s_ack),
          64'((i % 2 == 1) && i < 7));
    end
    drain(1'b0);

    // Backpressure in HI for 5 cycles.
    do_reset();
    push_word(0, 1, 1, 5'h0A, 64'h1122334455667788);
    push_word(0, 1, 1, 5'h0B, 64'h99AABBCCDDEEFF00);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1);
      chk("bp_valid", 64'(s_valid), 64'd1);
      chk("bp_data", 64'(out_data), 64'h11223344);
      chk("bp_ack", 64'(s_ack), 64'd0);
    end
    drain(1'b0);

    // mbe on word 2 of 4, then mbe on an eot word, then a clean frame.
    do_reset();
    push_word(0, 1, 0, 5'h11, 64'hA0A0A0A0B0B0B0B0);
    push_word(1, 0, 0, 5'h11, 64'h1);
    push_word(0, 0, 0, 5'h11, 64'h2);
    push_word(0, 0, 1, 5'h11, 64'h3);
    drain(1'b0);
    chk("mbe_stat", 64'(stat_mbe), 64'd1);
    chk("mbe_frames", 64'(stat_frames), 64'd1);
    push_word(0, 1, 0, 5'h12, 64'h4);
    push_word(1, 0, 1, 5'h12, 64'h5);
    push_word(0, 1, 1, 5'h13, 64'h0123456789ABCDEF);
    drain(1'b0);

    // Asynchronous reset while in HI.
    push_word(0, 1, 1, 5'h14, 64'h5555AAAA5555AAAA);
    tick(1'b0, 1'b1);
    #2;
    fifo_out_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_ack", 64'(fifo_out_ack), 64'd0);
    chk("arst_frames", 64'(stat_frames), 64'd0);
    chk("arst_mbe", 64'(stat_mbe), 64'd0);
    do_reset();
    push_word(0, 1, 0, 5'h15, 64'hFEEDFACE00000001);
    push_word(0, 0, 1, 5'h15, 64'hFEEDFACE00000002);
    drain(1'b0);

    // Random frames, random mbe, random ready and fifo bubbles.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(4, 1);
      for (int i = 0; i < len; i++)
        push_word($urandom_range(7) == 0, i == 0, i == len - 1,
                  5'($urandom), {$urandom, $urandom});
    end
    drain(1'b1);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < MAXC + 3; i++)
      push_word(0, 1, 1, 5'(i), {32'(i), 32'(~i)});
    drain(1'b0);
    chk("sat_frames", 64'(stat_frames), 64'(MAXC));
    for (int i = 0; i < MAXC + 3; i++)
      push_word(1, 1, 1, 5'(i), 64'(i));
    drain(1'b0);
    chk("sat_mbe", 64'(stat_mbe), 64'(MAXC));
    chk("sat_frames2", 64'(stat_frames), 64'(MAXC));

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
